// File: rtl/mips_decode_stage.sv
// Registered instruction-decode stage for the MIPS core.
// Classifies each instruction, extracts its GPR destination and extended
// immediate, and holds HI/LO-touching instructions back while the
// multiply/divide unit is still producing a result.
module mips_decode_stage #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 12,
  parameter bit          MADD_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_ir,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ir,
  output logic [3:0]  out_class,
  output logic        out_wr_en,
  output logic [4:0]  out_wr_reg,
  output logic [31:0] out_imm,
  output logic        mdu_busy
);

  localparam logic [3:0] CLS_ILLEGAL = 4'd0;
  localparam logic [3:0] CLS_ALU_R   = 4'd1;
  localparam logic [3:0] CLS_ALU_I   = 4'd2;
  localparam logic [3:0] CLS_SHIFT   = 4'd3;
  localparam logic [3:0] CLS_LOAD    = 4'd4;
  localparam logic [3:0] CLS_STORE   = 4'd5;
  localparam logic [3:0] CLS_BRANCH  = 4'd6;
  localparam logic [3:0] CLS_JUMP    = 4'd7;
  localparam logic [3:0] CLS_MDU     = 4'd8;
  localparam logic [3:0] CLS_HILO    = 4'd9;
  localparam logic [3:0] CLS_MOVC    = 4'd10;

  localparam logic [4:0] MULT_LOAD = 5'(MULT_LAT);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_LAT);

  // Instruction fields
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;

  assign opcode = in_ir[31:26];
  assign funct  = in_ir[5:0];
  assign rt     = in_ir[20:16];
  assign rd     = in_ir[15:11];

  // Immediate forms
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic [31:0] imm_lui;
  logic [31:0] imm_branch;
  logic [31:0] imm_jump;

  assign imm_sext   = {{16{in_ir[15]}}, in_ir[15:0]};
  assign imm_zext   = {16'h0000, in_ir[15:0]};
  assign imm_lui    = {in_ir[15:0], 16'h0000};
  assign imm_branch = {{14{in_ir[15]}}, in_ir[15:0], 2'b00};
  assign imm_jump   = {4'b0000, in_ir[25:0], 2'b00};

  // Decoded view of in_ir
  logic [3:0]  dec_class;
  logic        dec_wr_en;
  logic [4:0]  dec_wr_reg;
  logic [31:0] dec_imm;
  logic        dec_is_div;

  // Combinational decode of the incoming instruction word
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statements can leave one unassigned and infer a latch.
    dec_class  = CLS_ILLEGAL;
    dec_wr_en  = 1'b0;
    dec_wr_reg = 5'd0;
    dec_imm    = imm_sext;
    dec_is_div = 1'b0;

    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100000, 6'b100001, 6'b100010, 6'b100011,
          6'b100100, 6'b100101, 6'b100110, 6'b100111,
          6'b101010, 6'b101011: begin
            dec_class  = CLS_ALU_R;
            dec_wr_en  = 1'b1;
            dec_wr_reg = rd;
          end
          6'b000000, 6'b000010, 6'b000011,
          6'b000100, 6'b000110, 6'b000111: begin
            dec_class  = CLS_SHIFT;
            dec_wr_en  = 1'b1;
            dec_wr_reg = rd;
          end
          6'b001000: dec_class = CLS_JUMP;
          6'b001001: begin
            dec_class  = CLS_JUMP;
            dec_wr_en  = 1'b1;
            dec_wr_reg = rd;
          end
          6'b011000, 6'b011001: dec_class = CLS_MDU;
          6'b011010, 6'b011011: begin
            dec_class  = CLS_MDU;
            dec_is_div = 1'b1;
          end
          6'b010000, 6'b010010: begin
            dec_class  = CLS_HILO;
            dec_wr_en  = 1'b1;
            dec_wr_reg = rd;
          end
          6'b010001, 6'b010011: dec_class = CLS_HILO;
          6'b001010, 6'b001011: begin
            dec_class  = CLS_MOVC;
            dec_wr_en  = 1'b1;
            dec_wr_reg = rd;
          end
          default: ;
        endcase
      end
      6'b000001: begin
        // Only bltz (rt=0) and bgez (rt=1) are supported from REGIMM
        if (rt[4:1] == 4'd0) begin
          dec_class = CLS_BRANCH;
          dec_imm   = imm_branch;
        end
      end
      6'b000010: begin
        dec_class = CLS_JUMP;
        dec_imm   = imm_jump;
      end
      6'b000011: begin
        dec_class  = CLS_JUMP;
        dec_wr_en  = 1'b1;
        dec_wr_reg = 5'd31;
        dec_imm    = imm_jump;
      end
      6'b000100, 6'b000101, 6'b000110, 6'b000111: begin
        dec_class = CLS_BRANCH;
        dec_imm   = imm_branch;
      end
      6'b001000, 6'b001001, 6'b001010, 6'b001011: begin
        dec_class  = CLS_ALU_I;
        dec_wr_en  = 1'b1;
        dec_wr_reg = rt;
      end
      6'b001100, 6'b001101, 6'b001110: begin
        dec_class  = CLS_ALU_I;
        dec_wr_en  = 1'b1;
        dec_wr_reg = rt;
        dec_imm    = imm_zext;
      end
      6'b001111: begin
        dec_class  = CLS_ALU_I;
        dec_wr_en  = 1'b1;
        dec_wr_reg = rt;
        dec_imm    = imm_lui;
      end
      6'b011100: begin
        if (MADD_EN) begin
          case (funct)
            6'b000000, 6'b000001, 6'b000100, 6'b000101: dec_class = CLS_MDU;
            default: ;
          endcase
        end
      end
      6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: begin
        dec_class  = CLS_LOAD;
        dec_wr_en  = 1'b1;
        dec_wr_reg = rt;
      end
      6'b101000, 6'b101001, 6'b101010, 6'b101011, 6'b101110: begin
        dec_class = CLS_STORE;
      end
      default: ;
    endcase
  end

  // MDU occupancy counter and handshake
  logic [4:0] mdu_cnt;
  logic       hazard;
  logic       accept;

  assign hazard   = (mdu_cnt != 5'd0) &&
                    ((dec_class == CLS_MDU) || (dec_class == CLS_HILO));
  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;
  assign mdu_busy = (mdu_cnt != 5'd0);

  // Output entry register: load on accept, drop on consume or flush
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the datapath fields are reset as well, not just out_valid,
    // because their reset value is visible on the ports.
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_ir     <= 32'h0;
      out_class  <= CLS_ILLEGAL;
      out_wr_en  <= 1'b0;
      out_wr_reg <= 5'd0;
      out_imm    <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (accept) begin
        out_valid  <= 1'b1;
        out_ir     <= in_ir;
        out_class  <= dec_class;
        out_wr_en  <= dec_wr_en;
        out_wr_reg <= dec_wr_reg;
        out_imm    <= dec_imm;
      end else if (out_ready || flush) begin
        out_valid <= 1'b0;
      end
    end
  end

  // MDU counter: load on an accepted MDU op, otherwise count down to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdu_cnt <= 5'd0;
    end else if (accept && (dec_class == CLS_MDU)) begin
      mdu_cnt <= dec_is_div ? DIV_LOAD : MULT_LOAD;
    end else if (mdu_cnt != 5'd0) begin
      mdu_cnt <= mdu_cnt - 5'd1;
    end
  end

endmodule

// File: tb/tb_mips_decode_stage.sv
// Self-checking bench for mips_decode_stage. Two instances share stimulus:
// dut_a with madd decoding enabled, dut_b with it disabled.
module tb_mips_decode_stage;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 12;

  localparam int C_ILLEGAL = 0, C_ALU_R = 1, C_ALU_I = 2, C_SHIFT = 3, C_LOAD = 4,
                 C_STORE = 5, C_BRANCH = 6, C_JUMP = 7, C_MDU = 8, C_HILO = 9,
                 C_MOVC = 10;

  typedef struct packed {
    logic        valid;
    logic [31:0] ir;
    logic [3:0]  cls;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [31:0] imm;
    logic        busy;
  } view_t;

  typedef struct packed {
    logic [31:0] ir;
    logic [3:0]  cls;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [31:0] imm;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_ir = 32'h0;
  logic        out_ready = 1'b0;

  logic        a_in_ready, a_out_valid, a_out_wr_en, a_mdu_busy;
  logic [31:0] a_out_ir, a_out_imm;
  logic [3:0]  a_out_class;
  logic [4:0]  a_out_wr_reg;
  logic        b_in_ready, b_out_valid, b_out_wr_en, b_mdu_busy;
  logic [31:0] b_out_ir, b_out_imm;
  logic [3:0]  b_out_class;
  logic [4:0]  b_out_wr_reg;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int    op_cls  [int];
  int    fn_cls  [int];
  int    sp2_cls [int];
  view_t m     [2];
  int    m_cnt [2];

  always #5 clk = ~clk;

  mips_decode_stage #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .MADD_EN(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ir(in_ir),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_ir(a_out_ir), .out_class(a_out_class), .out_wr_en(a_out_wr_en),
    .out_wr_reg(a_out_wr_reg), .out_imm(a_out_imm), .mdu_busy(a_mdu_busy)
  );

  mips_decode_stage #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .MADD_EN(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ir(in_ir),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_ir(b_out_ir), .out_class(b_out_class), .out_wr_en(b_out_wr_en),
    .out_wr_reg(b_out_wr_reg), .out_imm(b_out_imm), .mdu_busy(b_mdu_busy)
  );

  // Mnemonic tables: opcode / funct value -> class
  task automatic build_tables();
    for (int o = 'h08; o <= 'h0f; o++) op_cls[o] = C_ALU_I;
    for (int o = 'h04; o <= 'h07; o++) op_cls[o] = C_BRANCH;
    op_cls['h02] = C_JUMP;  op_cls['h03] = C_JUMP;
    op_cls['h20] = C_LOAD;  op_cls['h21] = C_LOAD;  op_cls['h23] = C_LOAD;
    op_cls['h24] = C_LOAD;  op_cls['h25] = C_LOAD;
    op_cls['h28] = C_STORE; op_cls['h29] = C_STORE; op_cls['h2a] = C_STORE;
    op_cls['h2b] = C_STORE; op_cls['h2e] = C_STORE;
    for (int f = 'h20; f <= 'h27; f++) fn_cls[f] = C_ALU_R;
    fn_cls['h2a] = C_ALU_R; fn_cls['h2b] = C_ALU_R;
    fn_cls['h00] = C_SHIFT; fn_cls['h02] = C_SHIFT; fn_cls['h03] = C_SHIFT;
    fn_cls['h04] = C_SHIFT; fn_cls['h06] = C_SHIFT; fn_cls['h07] = C_SHIFT;
    fn_cls['h08] = C_JUMP;  fn_cls['h09] = C_JUMP;
    for (int f = 'h18; f <= 'h1b; f++) fn_cls[f] = C_MDU;
    for (int f = 'h10; f <= 'h13; f++) fn_cls[f] = C_HILO;
    fn_cls['h0a] = C_MOVC;  fn_cls['h0b] = C_MOVC;
    sp2_cls['h00] = C_MDU; sp2_cls['h01] = C_MDU; sp2_cls['h04] = C_MDU; sp2_cls['h05] = C_MDU;
  endtask

  // Decode an instruction from the mnemonic tables and field rules
  task automatic model_decode(input logic [31:0] ir, input bit madd_en, output int cls,
                              output bit wr_en, output int wr_reg, output logic [31:0] imm,
                              output int lat);
    int op, fn, rt, rd, s16;
    op = int'(ir[31:26]); fn = int'(ir[5:0]); rt = int'(ir[20:16]); rd = int'(ir[15:11]);
    s16 = int'(ir[15:0]);
    if (s16 >= 32768) s16 = s16 - 65536;
    cls = C_ILLEGAL;
    if (op == 0) begin
      if (fn_cls.exists(fn)) cls = fn_cls[fn];
    end else if (op == 1) begin
      if (rt <= 1) cls = C_BRANCH;
    end else if (op == 'h1c) begin
      if (madd_en && sp2_cls.exists(fn)) cls = sp2_cls[fn];
    end else if (op_cls.exists(op)) begin
      cls = op_cls[op];
    end
    wr_en = 1'b1;
    if (cls == C_ALU_R || cls == C_SHIFT || cls == C_MOVC ||
        (op == 0 && (fn == 'h10 || fn == 'h12 || fn == 'h09)))
      wr_reg = rd;
    else if (cls == C_ALU_I || cls == C_LOAD) wr_reg = rt;
    else if (op == 3) wr_reg = 31;
    else begin wr_en = 1'b0; wr_reg = 0; end
    if (op >= 'h0c && op <= 'h0e) imm = 32'(ir[15:0]);
    else if (op == 'h0f) imm = 32'(ir[15:0]) * 65536;
    else if (cls == C_BRANCH) imm = 32'(s16 * 4);
    else if (op == 2 || op == 3) imm = 32'(ir[25:0]) * 4;
    else imm = 32'(s16);
    lat = (op == 0 && (fn == 'h1a || fn == 'h1b)) ? DIV_LAT : MULT_LAT;
  endtask

  // Advance model k by one clock edge using the current input values
  task automatic model_step(input int k, input bit madd_en, output bit rdy);
    int cls, wr_reg, lat;
    bit wr_en, hazard, acc;
    logic [31:0] imm;
    model_decode(in_ir, madd_en, cls, wr_en, wr_reg, imm, lat);
    hazard = (m_cnt[k] > 0) && (cls == C_MDU || cls == C_HILO);
    rdy = (!m[k].valid || out_ready) && !hazard && !flush;
    acc = in_valid && rdy;
    if (acc) begin
      m[k].valid = 1'b1; m[k].ir = in_ir; m[k].cls = 4'(cls);
      m[k].wr_en = wr_en; m[k].wr_reg = 5'(wr_reg); m[k].imm = imm;
    end else if (out_ready || flush) begin
      m[k].valid = 1'b0;
    end
    if (acc && cls == C_MDU) m_cnt[k] = lat;
    else if (m_cnt[k] > 0) m_cnt[k] = m_cnt[k] - 1;
    m[k].busy = (m_cnt[k] != 0);
  endtask

  function automatic view_t dut_view(input int k);
    if (k == 0)
      return '{a_out_valid, a_out_ir, a_out_class, a_out_wr_en, a_out_wr_reg, a_out_imm, a_mdu_busy};
    return '{b_out_valid, b_out_ir, b_out_class, b_out_wr_en, b_out_wr_reg, b_out_imm, b_mdu_busy};
  endfunction

  function automatic logic [31:0] rand_ir();
    logic [31:0] r;
    int hot_fn [8] = '{'h18, 'h19, 'h1a, 'h1b, 'h10, 'h12, 'h11, 'h21};
    r = $urandom;
    case ($urandom_range(0, 9))
      0, 1: begin r[31:26] = 6'h00; r[5:0] = 6'(hot_fn[$urandom_range(0, 7)]); end
      2, 3: r[31:26] = 6'h00;
      4: begin r[31:26] = 6'h01; r[20:16] = 5'($urandom_range(0, 3)); end
      5: begin r[31:26] = 6'h1c; r[5:0] = 6'($urandom_range(0, 7)); end
      default: r[31:26] = 6'($urandom_range(0, 47));
    endcase
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_ir = 32'h0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_ir = 32'h012A4020; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (dut_view(k) !== '0) begin
        n_fail++; $display("FAIL reset_state dut%0d: got %h, want all zero", k, dut_view(k));
      end
    end
    n_checks++;
    if (a_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_decode();
    vec_t vecs [15] = '{
      '{32'h012A4020, 4'd1,  1'b1, 5'd8,  32'h00004020},
      '{32'h3C011234, 4'd2,  1'b1, 5'd1,  32'h12340000},
      '{32'h3402FFFF, 4'd2,  1'b1, 5'd2,  32'h0000FFFF},
      '{32'h2002FFFF, 4'd2,  1'b1, 5'd2,  32'hFFFFFFFF},
      '{32'h0C000001, 4'd7,  1'b1, 5'd31, 32'h00000004},
      '{32'h1000FFFF, 4'd6,  1'b0, 5'd0,  32'hFFFFFFFC},
      '{32'h0120F809, 4'd7,  1'b1, 5'd31, 32'hFFFFF809},
      '{32'hAC010004, 4'd5,  1'b0, 5'd0,  32'h00000004},
      '{32'h00004012, 4'd9,  1'b1, 5'd8,  32'h00004012},
      '{32'h0409FFFE, 4'd0,  1'b0, 5'd0,  32'hFFFFFFFE},
      '{32'h04010003, 4'd6,  1'b0, 5'd0,  32'h0000000C},
      '{32'h000A4840, 4'd3,  1'b1, 5'd9,  32'h00004840},
      '{32'h8D280010, 4'd4,  1'b1, 5'd8,  32'h00000010},
      '{32'h0109500B, 4'd10, 1'b1, 5'd10, 32'h0000500B},
      '{32'h08000010, 4'd7,  1'b0, 5'd0,  32'h00000040}
    };
    do_reset();
    out_ready = 1'b1;
    @(negedge clk);
    in_ir = vecs[0].ir; in_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({a_out_valid, a_out_ir, a_out_class, a_out_wr_en, a_out_wr_reg, a_out_imm} !== {1'b1, vecs[i]}) begin
        n_fail++;
        $display("FAIL decode[%0d] ir=%h: got v=%b ir=%h cls=%0d we=%b reg=%0d imm=%h, want cls=%0d we=%b reg=%0d imm=%h",
                 i, vecs[i].ir, a_out_valid, a_out_ir, a_out_class, a_out_wr_en, a_out_wr_reg, a_out_imm,
                 vecs[i].cls, vecs[i].wr_en, vecs[i].wr_reg, vecs[i].imm);
      end
      if (i < 14) in_ir = vecs[i + 1].ir;
      else in_valid = 1'b0;
    end
  endtask

  task automatic test_mdu_hazard();
    do_reset();
    out_ready = 1'b1;
    @(negedge clk);
    in_ir = 32'h012A0018; in_valid = 1'b1;
    #1;
    n_checks++;
    if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL mult_ready: got %b want 1", a_in_ready); end
    @(posedge clk);
    for (int t = 1; t <= 7; t++) begin
      @(negedge clk);
      n_checks++;
      if (a_mdu_busy !== (t <= 5)) begin
        n_fail++; $display("FAIL mdu_busy t=%0d: got %b want %b", t, a_mdu_busy, (t <= 5));
      end
      if (t == 1) begin
        in_ir = 32'h01095821;
        #1;
        n_checks++;
        if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL addu_no_stall: got %b want 1", a_in_ready); end
      end else if (t <= 6) begin
        if (t == 2) begin
          n_checks++;
          if (a_out_ir !== 32'h01095821) begin n_fail++; $display("FAIL addu_out_ir: got %h want 01095821", a_out_ir); end
        end
        in_ir = 32'h00004012;
        #1;
        n_checks++;
        if (a_in_ready !== (t == 6)) begin
          n_fail++; $display("FAIL mflo_ready t=%0d: got %b want %b", t, a_in_ready, (t == 6));
        end
      end else begin
        n_checks++;
        if ({a_out_valid, a_out_ir, a_out_class} !== {1'b1, 32'h00004012, 4'd9}) begin
          n_fail++; $display("FAIL mflo_out: got v=%b ir=%h cls=%0d want v=1 ir=00004012 cls=9",
                             a_out_valid, a_out_ir, a_out_class);
        end
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    in_ir = 32'h3C011234; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_ir = 32'h3402FFFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({a_in_ready, a_out_valid, a_out_ir, a_out_imm} !== {1'b0, 1'b1, 32'h3C011234, 32'h12340000}) begin
        n_fail++; $display("FAIL hold[%0d]: got rdy=%b v=%b ir=%h imm=%h want rdy=0 v=1 ir=3c011234 imm=12340000",
                           i, a_in_ready, a_out_valid, a_out_ir, a_out_imm);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b want 1", a_in_ready); end
    @(negedge clk);
    n_checks++;
    if ({a_out_valid, a_out_ir, a_out_imm} !== {1'b1, 32'h3402FFFF, 32'h0000FFFF}) begin
      n_fail++; $display("FAIL no_bubble: got v=%b ir=%h imm=%h want v=1 ir=3402ffff imm=0000ffff",
                         a_out_valid, a_out_ir, a_out_imm);
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL drain: got v=%b want 0", a_out_valid); end
  endtask

  task automatic test_flush_div();
    do_reset();
    @(negedge clk);
    in_ir = 32'h012A001A; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if ({a_out_valid, a_mdu_busy} !== 2'b11) begin
      n_fail++; $display("FAIL div_accept: got v=%b busy=%b want 1 1", a_out_valid, a_mdu_busy);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++;
    if ({a_out_valid, a_mdu_busy} !== 2'b01) begin
      n_fail++; $display("FAIL flush: got v=%b busy=%b want 0 1", a_out_valid, a_mdu_busy);
    end
    for (int t = 3; t <= 13; t++) begin
      @(negedge clk);
      n_checks++;
      if (a_mdu_busy !== (t <= DIV_LAT)) begin
        n_fail++; $display("FAIL div_busy t=%0d: got %b want %b", t, a_mdu_busy, (t <= DIV_LAT));
      end
    end
  endtask

  task automatic test_reset_midcount();
    do_reset();
    @(negedge clk);
    in_ir = 32'h012A0018; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_ir = 32'h00004012;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (dut_view(k) !== '0) begin
        n_fail++; $display("FAIL async_reset dut%0d: got %h want all zero", k, dut_view(k));
      end
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({a_out_valid, a_mdu_busy} !== 2'b00) begin
      n_fail++; $display("FAIL after_reset: got v=%b busy=%b want 0 0", a_out_valid, a_mdu_busy);
    end
  endtask

  task automatic test_madd_disabled();
    do_reset();
    out_ready = 1'b1;
    @(negedge clk);
    in_ir = 32'h712A0000; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if ({b_out_valid, b_out_class, b_out_wr_en, b_mdu_busy} !== {1'b1, 4'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL madd_off: got v=%b cls=%0d we=%b busy=%b want v=1 cls=0 we=0 busy=0",
                         b_out_valid, b_out_class, b_out_wr_en, b_mdu_busy);
    end
    n_checks++;
    if ({a_out_class, a_mdu_busy} !== {4'd8, 1'b1}) begin
      n_fail++; $display("FAIL madd_on: got cls=%0d busy=%b want cls=8 busy=1", a_out_class, a_mdu_busy);
    end
    repeat (6) begin
      @(negedge clk);
      n_checks++;
      if (b_mdu_busy !== 1'b0) begin n_fail++; $display("FAIL madd_off_busy: got %b want 0", b_mdu_busy); end
    end
  endtask

  task automatic test_random();
    bit rdy [2];
    do_reset();
    for (int k = 0; k < 2; k++) begin m[k] = '0; m_cnt[k] = 0; end
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (dut_view(k) !== m[k]) begin
          n_fail++;
          $display("FAIL random dut%0d cyc=%0d: got v=%b ir=%h cls=%0d we=%b reg=%0d imm=%h busy=%b, want v=%b ir=%h cls=%0d we=%b reg=%0d imm=%h busy=%b",
                   k, cyc, dut_view(k).valid, dut_view(k).ir, dut_view(k).cls, dut_view(k).wr_en,
                   dut_view(k).wr_reg, dut_view(k).imm, dut_view(k).busy, m[k].valid, m[k].ir,
                   m[k].cls, m[k].wr_en, m[k].wr_reg, m[k].imm, m[k].busy);
        end
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      in_ir     = rand_ir();
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      #1;
      model_step(0, 1'b1, rdy[0]);
      model_step(1, 1'b0, rdy[1]);
      n_checks++;
      if ({a_in_ready, b_in_ready} !== {rdy[0], rdy[1]}) begin
        n_fail++; $display("FAIL random_in_ready cyc=%0d ir=%h: got %b%b want %b%b",
                           cyc, in_ir, a_in_ready, b_in_ready, rdy[0], rdy[1]);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    build_tables();
    test_reset();
    test_decode();
    test_mdu_hazard();
    test_back_to_back();
    test_flush_div();
    test_reset_midcount();
    test_madd_disabled();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
